// File: rtl/destin_pkg.sv
// Shared definitions for the distance / minimum-comparator datapath.
//   DIST_W  : width of an accumulated L1 distance
//   NUM_CEN : number of centroids handled in parallel
//   state_t : two-state control FSM (ACC accumulates, HOLD presents a result)
//   sat16   : saturating DIST_W-bit add, also usable by the comparator tree
package destin_pkg;

  localparam int DIST_W  = 16;
  localparam int NUM_CEN = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Adds in DIST_W+1 bits and clamps anything past full scale to all ones.
  function automatic logic [DIST_W-1:0] sat16(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? {DIST_W{1'b1}} : s[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/abs_diff_acc_16bit.sv
// One centroid lane: |x - mu| accumulated with saturation.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : an element is accepted this cycle; update the accumulator
//   first      : this element starts a new vector (ignore the old total)
//   x, mu      : sample element and centroid element (unsigned DATA_W)
//   acc        : running total including the element presented now; this is
//                exactly the value the accumulator register loads when en=1,
//                so the parent can capture a finished vector on its last accept
module abs_diff_acc_16bit
  import destin_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] mu,
  output logic [DIST_W-1:0] acc
);

  logic [DIST_W-1:0] acc_reg;
  logic [DATA_W-1:0] diff;
  logic [DIST_W-1:0] base;

  assign diff = (x >= mu) ? (x - mu) : (mu - x);
  // Starting from zero on the first element removes the need for a clear cycle.
  assign base = first ? '0 : acc_reg;
  assign acc  = sat16(base, DIST_W'(diff));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc;
    end
  end

endmodule

// File: rtl/distance_calc_8cen_16bit.sv
// L1 distance from a streamed sample vector to 8 centroids.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : element handshake; in_ready is a pure state decode
//   x                    : current sample element
//   mu_000..mu_111       : element elem_idx of centroids 0..7
//   elem_idx             : index of the element expected next (centroid RAM address)
//   dist_000..dist_111   : finished distances, held until the next vector completes
//   out_valid / out_ready: result handshake
module distance_calc_8cen_16bit
  import destin_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] mu_000,
  input  logic [DATA_W-1:0] mu_001,
  input  logic [DATA_W-1:0] mu_010,
  input  logic [DATA_W-1:0] mu_011,
  input  logic [DATA_W-1:0] mu_100,
  input  logic [DATA_W-1:0] mu_101,
  input  logic [DATA_W-1:0] mu_110,
  input  logic [DATA_W-1:0] mu_111,
  output logic [IDX_W-1:0]  elem_idx,
  output logic [DIST_W-1:0] dist_000,
  output logic [DIST_W-1:0] dist_001,
  output logic [DIST_W-1:0] dist_010,
  output logic [DIST_W-1:0] dist_011,
  output logic [DIST_W-1:0] dist_100,
  output logic [DIST_W-1:0] dist_101,
  output logic [DIST_W-1:0] dist_110,
  output logic [DIST_W-1:0] dist_111,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  elem_idx_reg, elem_idx_next;
  logic              out_valid_reg, out_valid_next;
  logic              accept;
  logic              last_elem;
  logic              first_elem;

  logic [DATA_W-1:0] mu_arr   [NUM_CEN];
  logic [DIST_W-1:0] sum_arr  [NUM_CEN];
  logic [DIST_W-1:0] dist_reg [NUM_CEN];

  assign mu_arr[0] = mu_000;
  assign mu_arr[1] = mu_001;
  assign mu_arr[2] = mu_010;
  assign mu_arr[3] = mu_011;
  assign mu_arr[4] = mu_100;
  assign mu_arr[5] = mu_101;
  assign mu_arr[6] = mu_110;
  assign mu_arr[7] = mu_111;

  assign in_ready   = (state_reg == ACC);
  assign accept     = in_valid & in_ready;
  assign last_elem  = (elem_idx_reg == IDX_W'(VEC_LEN - 1));
  assign first_elem = (elem_idx_reg == '0);

  generate
    for (genvar gi = 0; gi < NUM_CEN; gi++) begin : g_lane
      abs_diff_acc_16bit #(
        .DATA_W(DATA_W)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .first(first_elem),
        .x    (x),
        .mu   (mu_arr[gi]),
        .acc  (sum_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    elem_idx_next  = elem_idx_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      ACC: begin
        if (accept) begin
          if (last_elem) begin
            elem_idx_next  = '0;
            state_next     = HOLD;
            out_valid_next = 1'b1;
          end else begin
            elem_idx_next = elem_idx_reg + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next     = ACC;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ACC;
      elem_idx_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      elem_idx_reg  <= elem_idx_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Results are only replaced when a vector completes, so they stay readable
  // while the next vector accumulates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CEN; k++) dist_reg[k] <= '0;
    end else if (accept && last_elem) begin
      for (int k = 0; k < NUM_CEN; k++) dist_reg[k] <= sum_arr[k];
    end
  end

  assign elem_idx  = elem_idx_reg;
  assign out_valid = out_valid_reg;
  assign dist_000  = dist_reg[0];
  assign dist_001  = dist_reg[1];
  assign dist_010  = dist_reg[2];
  assign dist_011  = dist_reg[3];
  assign dist_100  = dist_reg[4];
  assign dist_101  = dist_reg[5];
  assign dist_110  = dist_reg[6];
  assign dist_111  = dist_reg[7];

endmodule

// File: tb/tb_distance_calc_8cen_16bit.sv
module tb_distance_calc_8cen_16bit;

  typedef struct {
    int unsigned d[8];
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Short-vector instance
  logic        iv4, ir4, ov4, or4;
  logic [7:0]  x4;
  logic [7:0]  mu4 [8];
  logic [1:0]  idx4;
  logic [15:0] d4 [8];

  // Long-vector instance for saturation
  logic        iv300, ir300, ov300, or300;
  logic [7:0]  x300;
  logic [7:0]  mu300 [8];
  logic [8:0]  idx300;
  logic [15:0] d300 [8];

  distance_calc_8cen_16bit #(.VEC_LEN(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .x(x4),
    .mu_000(mu4[0]), .mu_001(mu4[1]), .mu_010(mu4[2]), .mu_011(mu4[3]),
    .mu_100(mu4[4]), .mu_101(mu4[5]), .mu_110(mu4[6]), .mu_111(mu4[7]),
    .elem_idx(idx4),
    .dist_000(d4[0]), .dist_001(d4[1]), .dist_010(d4[2]), .dist_011(d4[3]),
    .dist_100(d4[4]), .dist_101(d4[5]), .dist_110(d4[6]), .dist_111(d4[7]),
    .out_valid(ov4), .out_ready(or4)
  );

  distance_calc_8cen_16bit #(.VEC_LEN(300), .DATA_W(8)) dut300 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv300), .in_ready(ir300), .x(x300),
    .mu_000(mu300[0]), .mu_001(mu300[1]), .mu_010(mu300[2]), .mu_011(mu300[3]),
    .mu_100(mu300[4]), .mu_101(mu300[5]), .mu_110(mu300[6]), .mu_111(mu300[7]),
    .elem_idx(idx300),
    .dist_000(d300[0]), .dist_001(d300[1]), .dist_010(d300[2]), .dist_011(d300[3]),
    .dist_100(d300[4]), .dist_101(d300[5]), .dist_110(d300[6]), .dist_111(d300[7]),
    .out_valid(ov300), .out_ready(or300)
  );

  int checks = 0;
  int errors = 0;

  exp_t q4[$];
  exp_t q300[$];
  exp_t last4;
  int   res4_n = 0;
  int   res300_n = 0;

  int xs [4];
  int mus [4][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: L1 distance is the plain sum of absolute differences, clamped
  // to 16 bits once at the end (per-step clamping gives the same answer since
  // every term is non-negative).
  function automatic int unsigned clamp16(input int unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Scoreboard monitors: compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && ov4 === 1'b1 && or4 === 1'b1) begin
      exp_t e;
      string s;
      bit bad;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dut4_unexpected_result actual=out_valid required=no_result");
      end else begin
        e = q4.pop_front();
        bad = 0;
        s = "";
        for (int k = 0; k < 8; k++) begin
          if (d4[k] !== 16'(e.d[k])) bad = 1;
          s = {s, $sformatf(" %0d/%0d", d4[k], e.d[k])};
        end
        if (bad) begin
          errors++;
          $display("FAIL dut4_result#%0d actual/required:%s", res4_n, s);
        end else begin
          $display("RESULT dut4 #%0d ok dist:%s", res4_n, s);
        end
        res4_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov300 === 1'b1 && or300 === 1'b1) begin
      exp_t e;
      string s;
      bit bad;
      checks++;
      if (q300.size() == 0) begin
        errors++;
        $display("FAIL dut300_unexpected_result actual=out_valid required=no_result");
      end else begin
        e = q300.pop_front();
        bad = 0;
        s = "";
        for (int k = 0; k < 8; k++) begin
          if (d300[k] !== 16'(e.d[k])) bad = 1;
          s = {s, $sformatf(" %0d/%0d", d300[k], e.d[k])};
        end
        if (bad) begin
          errors++;
          $display("FAIL dut300_result#%0d actual/required:%s", res300_n, s);
        end else begin
          $display("RESULT dut300 #%0d ok dist:%s", res300_n, s);
        end
        res300_n++;
      end
    end
  end

  // mode 0: x=10, mu_k=k; mode 1: x=0, mu_k=200; mode 2: random
  task automatic fill(input int mode);
    for (int i = 0; i < 4; i++) begin
      xs[i] = (mode == 0) ? 10 : (mode == 1) ? 0 : int'($urandom_range(255));
      for (int k = 0; k < 8; k++)
        mus[i][k] = (mode == 0) ? k : (mode == 1) ? 200 : int'($urandom_range(255));
    end
  endtask

  task automatic load_elem(input int i);
    x4 = 8'(xs[i]);
    for (int k = 0; k < 8; k++) mu4[k] = 8'(mus[i][k]);
  endtask

  // Drives one vector into dut4. Entered and left at posedge+1.
  task automatic drive_vec4(input int gap_pct, input bit hold);
    int unsigned s[8];
    exp_t e;
    int n;
    for (int k = 0; k < 8; k++) s[k] = 0;
    or4 = !hold;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (gap_pct > 0 && n < 3 && int'($urandom_range(99)) < gap_pct) begin
        iv4 = 1'b0;
        x4  = 8'($urandom_range(255));
        @(negedge clk);
        chk("gap_elem_idx_hold", 32'(idx4), 32'(i));
        step();
        n++;
      end
      iv4 = 1'b1;
      load_elem(i);
      n = 0;
      @(negedge clk);
      while (ir4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (ir4 !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=%0b required=1", ir4);
      end
      chk("elem_idx_at_accept", 32'(idx4), 32'(i));
      for (int k = 0; k < 8; k++)
        s[k] += (xs[i] > mus[i][k]) ? xs[i] - mus[i][k] : mus[i][k] - xs[i];
      step();
    end
    iv4 = 1'b0;
    for (int k = 0; k < 8; k++) e.d[k] = clamp16(s[k]);
    q4.push_back(e);
    last4 = e;
    @(negedge clk);
    chk("out_valid_latency", 32'(ov4), 32'd1);
    chk("elem_idx_wrap", 32'(idx4), 32'd0);
    step();
    if (!hold) begin
      @(negedge clk);
      chk("out_valid_pulse_end", 32'(ov4), 32'd0);
      step();
    end
  endtask

  initial begin
    exp_t e;
    int bad;
    int unsigned s[8];

    rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; x4 = '0;
    iv300 = 1'b0; or300 = 1'b0; x300 = '0;
    for (int k = 0; k < 8; k++) begin
      mu4[k] = '0;
      mu300[k] = '0;
    end
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_elem_idx", 32'(idx4), 32'd0);
    chk("reset_out_valid", 32'(ov4), 32'd0);
    chk("reset_in_ready", 32'(ir4), 32'd1);
    chk("reset_dist_000", 32'(d4[0]), 32'd0);
    chk("reset_dist_111", 32'(d4[7]), 32'd0);
    chk("reset_elem_idx_300", 32'(idx300), 32'd0);
    step();

    // Basic: x=10, mu_k=k -> 40,36,...,12
    fill(0);
    drive_vec4(0, 1'b0);

    // Directionality: mu > x
    fill(1);
    drive_vec4(0, 1'b0);

    // Saturation on the long instance
    for (int k = 0; k < 8; k++) s[k] = 0;
    iv300 = 1'b1;
    x300  = 8'd255;
    mu300[0] = 8'd0;
    for (int k = 1; k < 8; k++) mu300[k] = 8'd255;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ir300 !== 1'b1 || idx300 !== 9'(i)) bad++;
      for (int k = 0; k < 8; k++)
        s[k] += (255 > int'(mu300[k])) ? 255 - int'(mu300[k]) : int'(mu300[k]) - 255;
      step();
    end
    iv300 = 1'b0;
    chk("sat_idx_sequence_errors", 32'(bad), 32'd0);
    for (int k = 0; k < 8; k++) e.d[k] = clamp16(s[k]);
    q300.push_back(e);
    or300 = 1'b1;
    @(negedge clk);
    chk("sat_out_valid_latency", 32'(ov300), 32'd1);
    step();
    @(negedge clk);
    chk("sat_out_valid_pulse_end", 32'(ov300), 32'd0);
    step();

    // Backpressure: result held while out_ready=0 and in_valid=1
    fill(2);
    drive_vec4(0, 1'b1);
    iv4 = 1'b1;
    x4  = 8'($urandom_range(255));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir4), 32'd0);
      chk("bp_elem_idx", 32'(idx4), 32'd0);
      chk("bp_out_valid", 32'(ov4), 32'd1);
      chk("bp_dist_000", 32'(d4[0]), last4.d[0]);
      chk("bp_dist_111", 32'(d4[7]), last4.d[7]);
      step();
    end
    fill(0);
    load_elem(0);
    or4 = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(ir4), 32'd0);
    step();
    @(negedge clk);
    chk("bp_after_out_valid", 32'(ov4), 32'd0);
    chk("bp_after_in_ready", 32'(ir4), 32'd1);
    chk("bp_after_elem_idx", 32'(idx4), 32'd0);
    step();
    @(negedge clk);
    chk("bp_next_accept_idx", 32'(idx4), 32'd1);
    load_elem(1);
    step();
    iv4 = 1'b0;
    or4 = 1'b0;

    // Reset mid-vector (two elements accepted)
    @(negedge clk);
    chk("mid_idx_before_reset", 32'(idx4), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_elem_idx", 32'(idx4), 32'd0);
    chk("mid_reset_out_valid", 32'(ov4), 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("mid_reset_dist%0d", k), 32'(d4[k]), 32'd0);
    step();
    fill(0);
    drive_vec4(0, 1'b0);

    // Back-to-back with gaps, out_ready tied high
    for (int v = 0; v < 2; v++) begin
      fill(2);
      drive_vec4(50, 1'b0);
    end

    // Random vectors with random result-acceptance delay
    for (int v = 0; v < 4; v++) begin
      fill(2);
      drive_vec4(30, 1'b1);
      repeat ($urandom_range(0, 3)) step();
      or4 = 1'b1;
      step();
      or4 = 1'b0;
    end

    repeat (3) step();
    chk("dut4_results_pending", 32'(q4.size()), 32'd0);
    chk("dut300_results_pending", 32'(q300.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/distance_calc_8cen_16bit.md
Name: distance_calc_8cen_16bit

Overview:
- Computes the L1 (Manhattan) distance between one streamed input vector and each of 8 centroids.
- Produces the eight 16-bit distances that feed the 8-centroid minimum comparator directly: dist_000..dist_111 map to its a_000..a_111 inputs.
- The sample and the centroid elements arrive one element per cycle under a valid/ready handshake.
- Results are held stable behind an out_valid/out_ready handshake until the consumer accepts them.

Parameters:
- VEC_LEN, 16: number of elements per vector; must be at least 2.
- DATA_W, 8: unsigned width of the sample and centroid elements.
- IDX_W, $clog2(VEC_LEN): width of the element index.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  x and mu_* are valid this cycle.
- in_ready  output  1  block accepts an element this cycle.
- x  input  DATA_W  current sample element.
- mu_000..mu_111  input  DATA_W each  element elem_idx of centroids 0..7.
- elem_idx  output  IDX_W  index of the element expected next; drives the centroid memory address.
- dist_000..dist_111  output  16 each  accumulated L1 distance per centroid.
- out_valid  output  1  dist_* hold a complete result.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all of the following are forced, overriding any handshake in flight:
  - state=ACC, elem_idx=0, out_valid=0;
  - all accumulators and dist_* = 0.
- The state machine has two states, ACC and HOLD. in_ready = (state==ACC); in_ready is a decode of state and has no combinational path from any input.
- ACC, element accept (in_valid & in_ready):
  - For each centroid lane k: acc_k <= sat16(base_k + |x - mu_k|).
  - base_k = 0 when elem_idx==0, otherwise acc_k. This makes clearing implicit, with no separate clear cycle.
  - |x - mu_k| is an unsigned DATA_W-bit absolute difference, zero-extended.
  - The sum is formed in 17 bits; sat16 clamps any result above 16'hFFFF to 16'hFFFF. Once a lane is saturated it stays saturated until the next vector.
  - elem_idx increments by 1.
- ACC, last element (accept with elem_idx==VEC_LEN-1):
  - The final sums are written to dist_*.
  - elem_idx wraps to 0, state goes to HOLD, out_valid=1 from the next cycle.
- ACC, in_valid=0: no state change and elem_idx holds. Idle gaps between elements are legal.
- HOLD: in_ready=0, and x and mu_* are ignored. dist_* and out_valid stay stable while out_ready=0.
- HOLD & out_ready: out_valid <= 0, state <= ACC.
  - dist_* keep their last value; they are only updated when a vector completes.
  - The next vector's first element can be accepted the following cycle.
- Latency and throughput:
  - out_valid rises 1 cycle after the last element is accepted.
  - Minimum interval is VEC_LEN+1 cycles per vector (VEC_LEN accepts plus 1 HOLD cycle with out_ready=1).
- elem_idx is registered and valid from reset. The mu_* inputs must be valid in the same cycle as the elem_idx value they correspond to (combinational or pre-fetched memory read).
- An out_ready that arrives while in ACC has no effect.

Decomposition:
- Shared package (destin_pkg):
  - DIST_W=16, NUM_CEN=8;
  - state enum {ACC, HOLD};
  - sat16 add function, reusable by the comparator tree.
- Sub-module abs_diff_acc_16bit, one per centroid lane, instantiated 8 times.
  - Inputs: clk, rst_n, en, first, x, mu.
  - Output: acc.
  - Contains the absolute difference, the saturating add and the accumulator register.
- The top level holds only the FSM, elem_idx and the dist_* output registers.

Test Plan:
- VEC_LEN=4, x=10 on every element, mu_k=k for all elements -> dist_000..dist_111 = 40,36,32,28,24,20,16,12; out_valid rises the cycle after the 4th accept.
- Directionality, VEC_LEN=4, x=0, mu_k=200 on every element -> all dist=800, which confirms the absolute difference is correct when mu > x.
- Saturation, VEC_LEN=300, x=255, mu_000=0 with all other mu=255 -> dist_000=16'hFFFF (raw 76500 clamped), all other dist=0.
- Backpressure: complete a vector, hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0, elem_idx stays 0, dist_* and out_valid unchanged; out_ready=1 -> out_valid=0 next cycle and the next element is accepted the cycle after.
- Reset mid-vector: accept 2 elements, then rst_n=0 for 1 cycle -> elem_idx=0, out_valid=0, dist=0; the next full vector gives the same result as the first test, with no residue from the aborted vector.
- Back-to-back with gaps: two vectors, in_valid toggling 1/0, out_ready tied to 1 -> each out_valid is a single-cycle pulse, elem_idx advances only on accepts, and the second result is independent of the first.
